// File: rtl/axi_slave_package.sv
// rtl/axi_slave_package.sv - shared types and sizes for the AXI slave request path
// Purpose : FSM state and TLP item kind enums, default AWLEN width.
// Ports   : none (package).
package axi_slave_package;

  localparam int AXI_MAX_NUM_TRANSFERS = 256;
  localparam int AXI_LEN_WIDTH         = $clog2(AXI_MAX_NUM_TRANSFERS);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WR_HDR,
    ARB_WR_DATA,
    ARB_RD_HDR
  } arb_state_t;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_WR_HDR,
    KIND_WR_DATA,
    KIND_RD_HDR
  } tlp_kind_t;

endpackage

// File: rtl/axi_rr_arb2.sv
// rtl/axi_rr_arb2.sv - two-requester (write/read) arbiter with round-robin memory
// Purpose : picks write or read when the scheduler is idle.
//           Default: round-robin, the side opposite the last grant wins a tie,
//           and the first tie after reset goes to write.
//           AXI_ARB_WR_PRIO_EN defined: fixed priority, write always wins a tie.
// Ports   : i_clk, i_rst_n (async active-low), i_req_wr, i_req_rd,
//           i_grant_en (grant allowed this cycle), o_gnt_wr, o_gnt_rd.
module axi_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_wr,
  input  logic i_req_rd,
  input  logic i_grant_en,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

`ifdef AXI_ARB_WR_PRIO_EN
  // No history is kept in fixed-priority mode.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = i_clk ^ i_rst_n;

  assign o_gnt_wr = i_grant_en & i_req_wr;
  assign o_gnt_rd = i_grant_en & i_req_rd & ~i_req_wr;
`else
  // 1 = last grant went to write; resets to read so the first tie goes to write.
  logic r_last_wr;

  assign o_gnt_wr = i_grant_en & i_req_wr & (~i_req_rd | ~r_last_wr);
  assign o_gnt_rd = i_grant_en & i_req_rd & ~o_gnt_wr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_wr <= 1'b0;
    end else if (o_gnt_wr) begin
      r_last_wr <= 1'b1;
    end else if (o_gnt_rd) begin
      r_last_wr <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/axi_req_arbiter.sv
// rtl/axi_req_arbiter.sv - pop-side scheduler from AXI AW/W/AR FIFOs to the TLP builder
// Purpose : arbitrates write vs read (credit gated), then sequences a write as
//           header + (aw_len+1) data beats, or a read as one header, holding the
//           grant until the whole transaction is handed downstream.
//           Optional macro AXI_ARB_WR_PRIO_EN selects fixed write priority.
// Ports   : ACLK, ARESETn (async active-low)
//           aw_empty, w_empty, ar_empty, aw_len  - FIFO status / AW head length
//           p_credit_ok, np_credit_ok            - credit flags, sampled at grant
//           tlp_ready                            - builder accepts current item
//           aw_pop, w_pop, ar_pop                - FIFO pops (valid&ready qualified)
//           tlp_valid, tlp_kind, tlp_last, busy  - item to builder, FSM status
module axi_req_arbiter
  import axi_slave_package::*;
#(
  parameter int LEN_WIDTH = AXI_LEN_WIDTH
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 aw_empty,
  input  logic                 w_empty,
  input  logic                 ar_empty,
  input  logic [LEN_WIDTH-1:0] aw_len,
  input  logic                 p_credit_ok,
  input  logic                 np_credit_ok,
  input  logic                 tlp_ready,
  output logic                 aw_pop,
  output logic                 w_pop,
  output logic                 ar_pop,
  output logic                 tlp_valid,
  output logic [1:0]           tlp_kind,
  output logic                 tlp_last,
  output logic                 busy
);

  arb_state_t            r_state;
  arb_state_t            w_next;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  tlp_kind_t             w_kind;
  logic                  w_gnt_wr;
  logic                  w_gnt_rd;
  logic                  w_beat_zero;

  axi_rr_arb2 u_arb (
    .i_clk      (ACLK),
    .i_rst_n    (ARESETn),
    .i_req_wr   (~aw_empty & p_credit_ok),
    .i_req_rd   (~ar_empty & np_credit_ok),
    .i_grant_en (r_state == ARB_IDLE),
    .o_gnt_wr   (w_gnt_wr),
    .o_gnt_rd   (w_gnt_rd)
  );

  assign w_beat_zero = (r_beat_cnt == '0);
  assign tlp_kind    = w_kind;
  assign busy        = (r_state != ARB_IDLE);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // beat_cnt holds the remaining beats after the current one; it stops at 0.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_beat_cnt <= '0;
    end else if (aw_pop) begin
      r_beat_cnt <= aw_len;
    end else if (w_pop && !w_beat_zero) begin
      r_beat_cnt <= r_beat_cnt - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next    = r_state;
    w_kind    = KIND_NONE;
    tlp_valid = 1'b0;
    tlp_last  = 1'b0;
    aw_pop    = 1'b0;
    w_pop     = 1'b0;
    ar_pop    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_wr) begin
          w_next = ARB_WR_HDR;
        end else if (w_gnt_rd) begin
          w_next = ARB_RD_HDR;
        end
      end
      ARB_WR_HDR: begin
        tlp_valid = 1'b1;
        w_kind    = KIND_WR_HDR;
        if (tlp_ready) begin
          aw_pop = 1'b1;
          w_next = ARB_WR_DATA;
        end
      end
      ARB_WR_DATA: begin
        // An empty W FIFO stalls the beat without popping or counting.
        tlp_valid = ~w_empty;
        w_kind    = KIND_WR_DATA;
        tlp_last  = w_beat_zero;
        if (!w_empty && tlp_ready) begin
          w_pop = 1'b1;
          if (w_beat_zero) begin
            w_next = ARB_IDLE;
          end
        end
      end
      ARB_RD_HDR: begin
        tlp_valid = 1'b1;
        w_kind    = KIND_RD_HDR;
        tlp_last  = 1'b1;
        if (tlp_ready) begin
          ar_pop = 1'b1;
          w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  a_no_pop_when_empty: assert property (@(posedge ACLK) disable iff (!ARESETn)
    !(aw_pop && aw_empty) && !(w_pop && w_empty) && !(ar_pop && ar_empty));

  a_single_pop: assert property (@(posedge ACLK) disable iff (!ARESETn)
    $onehot0({aw_pop, w_pop, ar_pop}));

endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb/tb_axi_req_arbiter.sv - directed table-driven bench for axi_req_arbiter
module tb_axi_req_arbiter;

  logic       ACLK;
  logic       ARESETn;
  logic       aw_empty, w_empty, ar_empty;
  logic [7:0] aw_len;
  logic       p_credit_ok, np_credit_ok, tlp_ready;
  logic       aw_pop, w_pop, ar_pop, tlp_valid, tlp_last, busy;
  logic [1:0] tlp_kind;

  axi_req_arbiter #(.LEN_WIDTH(8)) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .aw_empty     (aw_empty),
    .w_empty      (w_empty),
    .ar_empty     (ar_empty),
    .aw_len       (aw_len),
    .p_credit_ok  (p_credit_ok),
    .np_credit_ok (np_credit_ok),
    .tlp_ready    (tlp_ready),
    .aw_pop       (aw_pop),
    .w_pop        (w_pop),
    .ar_pop       (ar_pop),
    .tlp_valid    (tlp_valid),
    .tlp_kind     (tlp_kind),
    .tlp_last     (tlp_last),
    .busy         (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // expected packing: {aw_pop, w_pop, ar_pop, tlp_valid, tlp_kind[1:0], tlp_last, busy}
  localparam logic [7:0] E_IDLE = 8'b0000_0000;
  localparam logic [7:0] E_WHDR = 8'b1001_0101;
  localparam logic [7:0] E_WDAT = 8'b0101_1001;
  localparam logic [7:0] E_WLST = 8'b0101_1011;
  localparam logic [7:0] E_RHDR = 8'b0011_1111;

  typedef struct {
    logic       aw_e, w_e, ar_e;
    logic [7:0] len;
    logic       p, np, rdy;
    logic [7:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic aw_e, input logic w_e, input logic ar_e,
                              input logic [7:0] len, input logic p, input logic np,
                              input logic rdy, input logic [7:0] exp);
    vec_t v;
    v.aw_e = aw_e; v.w_e = w_e; v.ar_e = ar_e; v.len = len;
    v.p = p; v.np = np; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = {aw_pop, w_pop, ar_pop, tlp_valid, tlp_kind, tlp_last, busy};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic aw_e, input logic w_e, input logic ar_e,
                       input logic [7:0] len, input logic p, input logic np, input logic rdy);
    aw_empty = aw_e; w_empty = w_e; ar_empty = ar_e; aw_len = len;
    p_credit_ok = p; np_credit_ok = np; tlp_ready = rdy;
  endtask

  vec_t tbl[20];
  int   order[6];

  initial begin
    int g, aw_n, ar_n, w_n, wp_cnt, ap_cnt, last_cnt, stall;
    bit hdr_done, done;

    ARESETn = 1'b0;
    drive(1, 1, 1, 8'd0, 0, 0, 0);

    // write only, aw_len=3, 4 W beats
    tbl[0]  = mk(0, 0, 1, 8'd3, 1, 1, 1, E_IDLE);
    tbl[1]  = mk(0, 0, 1, 8'd3, 1, 1, 1, E_WHDR);
    tbl[2]  = mk(1, 0, 1, 8'd3, 1, 1, 1, E_WDAT);
    tbl[3]  = mk(1, 0, 1, 8'd3, 1, 1, 1, E_WDAT);
    tbl[4]  = mk(1, 0, 1, 8'd3, 1, 1, 1, E_WDAT);
    tbl[5]  = mk(1, 0, 1, 8'd3, 1, 1, 1, E_WLST);
    tbl[6]  = mk(1, 1, 1, 8'd3, 1, 1, 1, E_IDLE);
    // read only, two AR entries with one idle bubble between
    tbl[7]  = mk(1, 1, 0, 8'd0, 1, 1, 1, E_IDLE);
    tbl[8]  = mk(1, 1, 0, 8'd0, 1, 1, 1, E_RHDR);
    tbl[9]  = mk(1, 1, 0, 8'd0, 1, 1, 1, E_IDLE);
    tbl[10] = mk(1, 1, 0, 8'd0, 1, 1, 1, E_RHDR);
    tbl[11] = mk(1, 1, 1, 8'd0, 1, 1, 1, E_IDLE);
    // credit gating: no posted credit -> read; credit back -> write
    tbl[12] = mk(0, 0, 0, 8'd0, 0, 1, 1, E_IDLE);
    tbl[13] = mk(0, 0, 0, 8'd0, 0, 1, 1, E_RHDR);
    tbl[14] = mk(0, 0, 0, 8'd0, 1, 1, 1, E_IDLE);
    tbl[15] = mk(0, 0, 0, 8'd0, 1, 1, 1, E_WHDR);
    tbl[16] = mk(1, 0, 0, 8'd0, 1, 1, 1, E_WLST);
    tbl[17] = mk(1, 1, 0, 8'd0, 1, 1, 1, E_IDLE);
    tbl[18] = mk(1, 1, 0, 8'd0, 1, 1, 1, E_RHDR);
    tbl[19] = mk(1, 1, 1, 8'd0, 1, 1, 1, E_IDLE);

    #12;
    check("reset_outputs", E_IDLE);
    @(negedge ACLK);
    ARESETn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].aw_e, tbl[i].w_e, tbl[i].ar_e, tbl[i].len, tbl[i].p, tbl[i].np, tbl[i].rdy);
      #1;
      check($sformatf("table_cycle%0d", i + 1), tbl[i].exp);
      @(negedge ACLK);
    end

    // contention: 3 writes (aw_len=0) and 3 reads queued
    aw_n = 3; ar_n = 3; w_n = 3; g = 0;
    for (int c = 0; c < 100 && g < 6; c++) begin
      drive(aw_n == 0, w_n == 0, ar_n == 0, 8'd0, 1, 1, 1);
      #1;
      if (aw_pop) begin order[g] = 0; g++; aw_n--; end
      if (ar_pop) begin order[g] = 1; g++; ar_n--; end
      if (w_pop) w_n--;
      @(negedge ACLK);
    end
    check_int("contention_grant_count", g, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef AXI_ARB_WR_PRIO_EN
      check_int($sformatf("contention_grant%0d(0=WR,1=RD)", i), order[i], (i < 3) ? 0 : 1);
`else
      check_int($sformatf("contention_grant%0d(0=WR,1=RD)", i), order[i], i % 2);
`endif
    end

    // stall and backpressure: aw_len=1, W empty 5 cycles after header, ready toggling
    aw_n = 1; w_n = 2; stall = 0; hdr_done = 0; wp_cnt = 0; ap_cnt = 0; done = 0;
    for (int k = 0; k < 80; k++) begin
      drive(aw_n == 0, (w_n == 0) || (hdr_done && stall < 5), 1, 8'd1, 1, 1, (k % 2) == 0);
      #1;
      if (w_pop && (w_empty || !tlp_ready)) check_int("stall_pop_qualified", 1, 0);
      if (w_pop) begin
        check_int($sformatf("stall_beat%0d_last", wp_cnt), tlp_last, wp_cnt == 1);
        wp_cnt++; w_n--;
      end
      if (aw_pop) begin ap_cnt++; aw_n--; end
      if (wp_cnt == 2 && !busy) begin done = 1; break; end
      if (hdr_done && stall < 5) stall++;
      if (aw_pop) hdr_done = 1;
      @(negedge ACLK);
    end
    check_int("stall_completed", done, 1);
    check_int("stall_w_pops", wp_cnt, 2);
    check_int("stall_aw_pops", ap_cnt, 1);
    @(negedge ACLK);

    // maximum length write: aw_len=255 -> 256 data pops, tlp_last once
    aw_n = 1; wp_cnt = 0; last_cnt = 0; hdr_done = 0; done = 0;
    for (int k = 0; k < 400; k++) begin
      drive(aw_n == 0, 0, 1, 8'd255, 1, 1, 1);
      #1;
      if (aw_pop) begin aw_n--; hdr_done = 1; end
      if (w_pop) wp_cnt++;
      if (w_pop && tlp_last) last_cnt++;
      if (hdr_done && !busy) begin done = 1; break; end
      @(negedge ACLK);
    end
    check_int("maxlen_completed", done, 1);
    check_int("maxlen_w_pops", wp_cnt, 256);
    check_int("maxlen_last_count", last_cnt, 1);
    @(negedge ACLK);

    // reset mid-write once beat_cnt has reached 100 (aw_len=150, 50 beats popped)
    aw_n = 1; wp_cnt = 0;
    for (int k = 0; k < 300 && wp_cnt < 50; k++) begin
      drive(aw_n == 0, 0, 1, 8'd150, 1, 1, 1);
      #1;
      if (aw_pop) aw_n--;
      if (w_pop) wp_cnt++;
      @(negedge ACLK);
    end
    check_int("midreset_beats_before", wp_cnt, 50);
    #1;
    check("midreset_in_wr_data", E_WDAT);
    #2;
    ARESETn = 1'b0;
    #1;
    check("midreset_async_outputs", E_IDLE);
    @(negedge ACLK);
    ARESETn = 1'b1;
    drive(0, 0, 0, 8'd0, 1, 1, 1);
    #1;
    check("postreset_idle", E_IDLE);
    @(negedge ACLK);
    #1;
    check("postreset_contended_write", E_WHDR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_req_arbiter.md
Name: axi_req_arbiter

Overview:
- Pop-side scheduler between the AXI slave request FIFOs (AW+W write path, AR read path) and the single TLP header/data builder in TL TX.
- Round-robin arbitration between write and read requests, gated by posted and non-posted credit flags.
- Sequences one write as header pop plus N data-beat pops, and one read as a single header pop.
- Holds the grant until the whole transaction has been handed downstream.

Parameters:
- LEN_WIDTH, 8, width of the AWLEN beat count ($clog2(AXI_MAX_NUM_TRANSFERS)); a value of n means n+1 beats.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- aw_empty  in  1  AW FIFO empty
- w_empty  in  1  W FIFO empty
- ar_empty  in  1  AR FIFO empty
- aw_len  in  LEN_WIDTH  AWLEN of the AW FIFO head entry (valid when !aw_empty)
- p_credit_ok  in  1  posted header+data credit available
- np_credit_ok  in  1  non-posted header credit available
- tlp_ready  in  1  downstream builder accepts the current item
- aw_pop  out  1  pop AW FIFO
- w_pop  out  1  pop W FIFO
- ar_pop  out  1  pop AR FIFO
- tlp_valid  out  1  item presented to builder
- tlp_kind  out  2  00 none, 01 write header, 10 write data, 11 read header
- tlp_last  out  1  final item of the current TLP
- busy  out  1  state != IDLE

Behaviour:
- Single clock ACLK; asynchronous active-low reset ARESETn.
- Reset values: state=IDLE, beat_cnt=0, last_grant=RD, all outputs 0.
- Eligibility in IDLE: wr_elig = !aw_empty & p_credit_ok; rd_elig = !ar_empty & np_credit_ok.
- Arbitration (IDLE only, registered):
  - Only one eligible -> it wins.
  - Both eligible -> the side opposite last_grant wins; last_grant updates on grant.
  - Neither eligible -> stay IDLE.
  - First contended grant after reset goes to write.
- Credits are sampled only at grant. Loss of credit mid-transaction does not abort it.
- States: IDLE, WR_HDR, WR_DATA, RD_HDR.
- WR_HDR:
  - tlp_valid=1, tlp_kind=01, tlp_last=0.
  - On tlp_ready: aw_pop=1 (combinational, same cycle), beat_cnt<=aw_len, go to WR_DATA.
- WR_DATA:
  - tlp_valid = !w_empty, tlp_kind=10, tlp_last = (beat_cnt==0).
  - On tlp_valid&tlp_ready: w_pop=1.
  - If beat_cnt==0, go to IDLE; otherwise beat_cnt-=1.
  - W FIFO empty stalls with tlp_valid=0 and no pop; state and count hold.
- RD_HDR:
  - tlp_valid=1, tlp_kind=11, tlp_last=1.
  - On tlp_ready: ar_pop=1, go to IDLE.
- Pops are strictly valid&ready qualified. At most one pop output is high per cycle.
- Any pop while the corresponding FIFO is empty is a design error (assertion).
- One IDLE bubble cycle between transactions. Grant-to-first-tlp_valid latency is 1 cycle.
- Max write is 2^LEN_WIDTH beats: aw_len=255 gives 256 data pops. beat_cnt never wraps below 0.
- tlp_ready held low: outputs stay stable, no pops.
- Reset asserted mid-transaction: immediate return to IDLE. Partially consumed W beats are not recovered; flushing is the FIFO owner's job.
- With no reset, tlp_kind=00 and tlp_valid=0 whenever in IDLE.

Optional Feature:
- Macro AXI_ARB_WR_PRIO_EN.
- Defined: fixed priority. Write always wins when both are eligible; last_grant is unused (tied off).
- Undefined: round-robin as described above.

Decomposition:
- Shared package (axi_slave_package) gets:
  - typedef enum arb_state_t {ARB_IDLE, ARB_WR_HDR, ARB_WR_DATA, ARB_RD_HDR};
  - typedef enum logic [1:0] tlp_kind_t {KIND_NONE, KIND_WR_HDR, KIND_WR_DATA, KIND_RD_HDR};
  - LEN_WIDTH default from $clog2(AXI_MAX_NUM_TRANSFERS).
- One natural sub-module: axi_rr_arb2 (2-requester round-robin with last_grant register and the AXI_ARB_WR_PRIO_EN option).
- The FSM and beat counter stay in the top module.

Test Plan:
- Write only: aw_len=3, W FIFO holding 4 beats, tlp_ready=1 -> aw_pop in cycle 2; w_pop in cycles 3-6; tlp_last in cycle 6; busy back to 0 in cycle 7.
- Read only: AR FIFO holding 2 entries, np_credit_ok=1 -> two RD_HDR items with tlp_last=1 each, ar_pop twice, 1-cycle IDLE gap between them.
- Contention: AW and AR both non-empty, both credits ok, 3 transactions each, aw_len=0 -> grant order WR,RD,WR,RD,WR,RD. With AXI_ARB_WR_PRIO_EN -> WR,WR,WR,RD,RD,RD.
- Credit gating: p_credit_ok=0, both FIFOs non-empty -> read granted, no aw_pop. Raise p_credit_ok -> write granted next.
- Stall and backpressure: aw_len=1, w_empty=1 for 5 cycles after header, tlp_ready toggling -> no w_pop while empty or !tlp_ready; exactly 2 w_pop in total; beat_cnt holds during stalls.
- Reset mid-write: assert ARESETn=0 during WR_DATA with beat_cnt=100 -> all outputs 0 asynchronously; after release, state=IDLE and a contended grant goes to write.
